// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the hart-to-memory line arbiter.
// The bus_arb top and its line buffer both import this package.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RD_I,
    RD_D,
    WR
  } op_t;

  localparam int LINE_OFFS_W = 7;
  localparam int BEAT_OFFS_W = 3;

endpackage

// File: rtl/bus_arb_line_buf.sv
// Cache-line buffer: full-line load, beat-granular insert, and beat extract by index.
// A single buffer is shared by the write data path and both read reply paths.
module bus_line_buf #(
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64,
  localparam int IDX_W = $clog2(LINE_W / BEAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [LINE_W-1:0] line
);

  // A full-line load and a beat insert never coincide, because the load
  // happens only on a write grant and inserts happen only during reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (wr_en) begin
      line[BEAT_W*int'(wr_idx) +: BEAT_W] <= wr_beat;
    end
  end

  assign rd_beat = line[BEAT_W*int'(rd_idx) +: BEAT_W];

endmodule

// File: rtl/bus_arb.sv
// Arbitrates the hart's instruction-refill and data buses onto one 64-bit valid/ack
// memory port. Each line is serialised into 16 beats.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  input  logic [LINE_W-1:0] b_data_out,
  input  logic              b_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_req,
  output logic              m_we,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic [BEAT_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W-LINE_OFFS_W){1'b1}}, {LINE_OFFS_W{1'b0}}};

  state_t            state;
  op_t               op;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  beat;
  logic              guard;

  op_t               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_base;
  logic              any_req;
  logic [IDX_W-1:0]  next_beat;
  logic [ADDR_W-1:0] next_addr;

  logic              buf_load;
  logic              buf_wr;
  logic [IDX_W-1:0]  buf_rd_idx;
  logic [BEAT_W-1:0] buf_rd_beat;
  logic [LINE_W-1:0] buf_line;

  // Fixed priority: data write, then data read, then instruction refill.
  always_comb begin
    req_op   = RD_I;
    req_addr = b_addr_i;
    if (b_wr) begin
      req_op   = WR;
      req_addr = b_addr;
    end else if (b_rd) begin
      req_op   = RD_D;
      req_addr = b_addr;
    end
  end

  assign any_req   = b_wr | b_rd | b_rd_i;
  assign req_base  = req_addr & LINE_MASK;
  assign next_beat = beat + 1'b1;
  assign next_addr = base | ADDR_W'({next_beat, {BEAT_OFFS_W{1'b0}}});

  assign buf_load   = (state == IDLE) && !guard && b_wr;
  assign buf_wr     = (state == XFER) && m_req && m_ack && (op != WR);
  assign buf_rd_idx = (state == IDLE) ? '0 : next_beat;

  bus_line_buf #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_line (b_data_out),
    .wr_en     (buf_wr),
    .wr_idx    (beat),
    .wr_beat   (m_rdata),
    .rd_idx    (buf_rd_idx),
    .rd_beat   (buf_rd_beat),
    .line      (buf_line)
  );

  assign b_data_i  = buf_line;
  assign b_data_in = buf_line;

  // Memory-port outputs are registered one beat ahead, so each ack edge loads
  // the address and write data of the following beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= RD_I;
      base    <= '0;
      beat    <= '0;
      guard   <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      b_dv_i  <= 1'b0;
      b_dv    <= 1'b0;
    end else begin
      b_dv_i <= 1'b0;
      b_dv   <= 1'b0;
      case (state)
        IDLE: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (any_req) begin
            op      <= req_op;
            base    <= req_base;
            beat    <= '0;
            state   <= XFER;
            m_req   <= 1'b1;
            m_we    <= (req_op == WR);
            m_addr  <= req_base;
            m_wdata <= (req_op == WR) ? b_data_out[BEAT_W-1:0] : buf_rd_beat;
          end
        end
        XFER: begin
          if (m_ack) begin
            beat <= next_beat;
            if (beat == IDX_W'(BEATS-1)) begin
              state  <= DONE;
              m_req  <= 1'b0;
              m_we   <= 1'b0;
              b_dv_i <= (op == RD_I);
              b_dv   <= (op != RD_I);
            end else begin
              m_addr  <= next_addr;
              m_wdata <= buf_rd_beat;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          guard <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Sits directly downstream of the hart and arbitrates its two line-granular buses onto one narrow memory port.
- The two hart buses are the instruction refill bus and the data bus (refill plus writeback).
- Each 1024-bit cache-line transfer is serialised into 64-bit beats on a valid/ack memory port.
- Replies return to the hart as a full line with a one-cycle data-valid pulse.

Parameters:
ADDR_W, 64, address width on all buses
LINE_W, 1024, cache line width in bits (line = 128 B)
BEAT_W, 64, memory beat width; BEATS = LINE_W/BEAT_W = 16 (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  reset. Synchronous, active-high; one clock domain.
b_addr_i  in  ADDR_W  instruction line address; low 7 bits ignored
b_rd_i  in  1  instruction line read request (level)
b_data_i  out  LINE_W  instruction line data
b_dv_i  out  1  instruction data valid (1-cycle pulse)
b_addr  in  ADDR_W  data-side line address; low 7 bits ignored
b_rd  in  1  data line read request (level)
b_data_in  out  LINE_W  data line read data
b_dv  out  1  data-side done pulse (read or write)
b_data_out  in  LINE_W  data line to write back
b_wr  in  1  data line write request (level)
m_addr  out  ADDR_W  beat address
m_req  out  1  beat request
m_we  out  1  1 = write beat
m_wdata  out  BEAT_W  write beat data
m_rdata  in  BEAT_W  read beat data, valid when m_req & m_ack
m_ack  in  1  beat accepted/returned this cycle

Behaviour:
- FSM states: IDLE, XFER, DONE.
- Reset: state IDLE; all outputs 0; line buffer and beat counter cleared. Reset mid-burst abandons the burst, m_req is low from the next cycle, and no dv is issued.
- IDLE, sampling requests in priority order:
  - b_wr first: op WR.
  - b_rd second: op RD_D.
  - b_rd_i third: op RD_I.
  - Requests are ignored in the single IDLE cycle that immediately follows DONE (turnaround guard).
  - On grant, latch: op; base = {addr[63:7],7'b0}; for WR, also b_data_out into the line buffer. Then go to XFER with beat = 0.
- XFER:
  - Drive m_req=1, m_we=(op==WR), m_addr=base+{beat,3'b000}, m_wdata=buf[64*beat+:64].
  - Outputs are held stable until m_ack. On m_req&m_ack, beat increments.
  - For reads, m_rdata is written into buf[64*beat+:64] on that edge.
  - m_req stays high back-to-back across beats.
  - After beat 15 is acked, go to DONE; m_req goes 0 in DONE.
- DONE (exactly 1 cycle):
  - op RD_I: b_dv_i=1.
  - op RD_D or WR: b_dv=1.
  - Then return to IDLE.
- Data outputs: b_data_i and b_data_in are both driven from the single line buffer. They are valid during the dv pulse and stay stable until the next grant.
- Latency: with m_ack tied high, a grant on edge k produces dv high in the cycle following edge k+16. This gives 17 cycles from grant to dv, plus 1 turnaround cycle before the next grant.
- b_wr and b_rd both high: the write is served first. The read stays pending and wins the next arbitration over b_rd_i.
- Requesters must keep their request and address stable until their dv. Dropping a request mid-transfer does not abort it; dv is still issued.
- Beat counter is 4 bits and wraps 15→0 only on the DONE transition. Address arithmetic stays within the line, so no carry into bit 7.
- Fixed priority: instruction refills can starve under continuous data traffic. This is accepted, because the hart stalls on data misses.

Decomposition:
- Shared package holds:
  - state enum {IDLE, XFER, DONE}
  - op enum {RD_I, RD_D, WR}
  - LINE_OFFS_W=7 and BEAT_OFFS_W=3
- One natural sub-module: bus_line_buf.
  - Contains the LINE_W register plus beat insert and extract by index, and full-line load.
  - bus_arb keeps the FSM, arbitration and address generation.

Test Plan:
- b_rd_i=1, b_addr_i=0x1234, m_ack=1, memory returns beat i = 0x1000+i → m_addr sequence 0x1200..0x1278 step 8; b_dv_i pulses once, 17 cycles after grant; b_data_i[64*i+:64]=0x1000+i; b_dv stays 0.
- b_wr=1, b_addr=0x80, b_data_out beat i = 0xA0+i → 16 beats with m_we=1, m_addr 0x80..0xF8, m_wdata 0xA0..0xAF; single b_dv pulse; b_dv_i stays 0.
- b_wr, b_rd and b_rd_i all asserted at once → three transfers in order WR, RD_D, RD_I; the three dv pulses are separated by ≥18 cycles.
- m_ack held low 3 cycles on beat 5 → m_addr/m_wdata stable during the stall, beat 5 not repeated, total latency +3.
- rst=1 on beat 7 of a read → next cycle m_req=0, state IDLE, no dv issued; the request re-asserted after reset restarts at beat 0.
- b_rd held high 2 cycles past its dv → no second transfer is granted in the guard cycle.
